// File: rtl/keypad_entry_sequencer.sv
// Keypad entry sequencer: buffers digit keys, compares against a stored password on '*',
// reprograms the password in the program state and times a key lockout in the lock state.
module keypad_entry_sequencer #(
    parameter int unsigned              DIGITS      = 4,
    parameter int unsigned              LOCK_CYCLES = 1000,
    parameter logic [4*DIGITS-1:0]      DEFAULT_PW  = 16'h1234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [2:0] state,
    output logic       is_star_pressed,
    output logic       correct,
    output logic       pw_updated,
    output logic       entry_error,
    output logic       lockout_active,
    output logic [2:0] digit_count
);

    localparam int unsigned BufW  = 4 * DIGITS;
    localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LockW-1:0] LockLoad = LockW'(LOCK_CYCLES - 1);
    localparam logic [2:0]       Full     = 3'(DIGITS);

    localparam logic [2:0] StOff    = 3'b000;
    localparam logic [2:0] StAnswer = 3'b100;
    localparam logic [2:0] StProg   = 3'b101;
    localparam logic [2:0] StUnused = 3'b110;
    localparam logic [2:0] StLock   = 3'b111;

    localparam logic [3:0] KeyStar  = 4'hA;
    localparam logic [3:0] KeyClear = 4'hB;

    logic [BufW-1:0]  pw_q, pw_d;
    logic [BufW-1:0]  buf_q, buf_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       prev_state_q, prev_state_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic             lockout_q, lockout_d;
    logic             star_q, star_d;
    logic             correct_q, correct_d;
    logic             pw_upd_q, pw_upd_d;
    logic             err_q, err_d;

    logic key_ok;
    logic match;

    assign key_ok = key_valid && !lockout_q && (state != StOff) && (state != StAnswer) &&
                    (state != StUnused);
    assign match  = (cnt_q == Full) && (buf_q == pw_q);

    // Next-state: lockout timer, state-change clear, and per-key decode.
    always_comb begin
        pw_d         = pw_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        prev_state_d = state;
        lock_cnt_d   = lock_cnt_q;
        lockout_d    = lockout_q;
        star_d       = 1'b0;
        correct_d    = 1'b0;
        pw_upd_d     = 1'b0;
        err_d        = 1'b0;

        // Active flag stays up for the cycle in which the counter sits at zero.
        if (lockout_q) begin
            if (lock_cnt_q == '0) lockout_d = 1'b0;
            else                  lock_cnt_d = lock_cnt_q - 1'b1;
        end

        if (state == StLock && prev_state_q != StLock) begin
            lock_cnt_d = LockLoad;
            lockout_d  = 1'b1;
        end

        // A state change wipes the entry and swallows any key in the same cycle.
        if (state != prev_state_q) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (key_ok) begin
            if (key_code <= 4'd9) begin
                if (cnt_q < Full) begin
                    buf_d = {buf_q[BufW-5:0], key_code};
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (key_code == KeyClear) begin
                buf_d = '0;
                cnt_d = '0;
            end else if (key_code == KeyStar) begin
                buf_d = '0;
                cnt_d = '0;
                if (state == StProg) begin
                    if (cnt_q == Full) begin
                        pw_d     = buf_q;
                        pw_upd_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    star_d    = 1'b1;
                    correct_d = match;
                    if (state == StLock && !match) begin
                        lock_cnt_d = LockLoad;
                        lockout_d  = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pw_q         <= DEFAULT_PW;
            buf_q        <= '0;
            cnt_q        <= '0;
            prev_state_q <= StOff;
            lock_cnt_q   <= '0;
            lockout_q    <= 1'b0;
            star_q       <= 1'b0;
            correct_q    <= 1'b0;
            pw_upd_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pw_q         <= pw_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            prev_state_q <= prev_state_d;
            lock_cnt_q   <= lock_cnt_d;
            lockout_q    <= lockout_d;
            star_q       <= star_d;
            correct_q    <= correct_d;
            pw_upd_q     <= pw_upd_d;
            err_q        <= err_d;
        end
    end

    assign is_star_pressed = star_q;
    assign correct         = correct_q;
    assign pw_updated      = pw_upd_q;
    assign entry_error     = err_q;
    assign lockout_active  = lockout_q;
    assign digit_count     = cnt_q;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Bench for keypad_entry_sequencer: directed vector table, hand-written reset sequence,
// and random stimulus against a queue-based reference model.
module tb_keypad_entry_sequencer;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned LOCK   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] state;
    logic       is_star_pressed, correct, pw_updated, entry_error, lockout_active;
    logic [2:0] digit_count;

    always #5 clk = ~clk;

    keypad_entry_sequencer #(
        .DIGITS      (DIGITS),
        .LOCK_CYCLES (LOCK),
        .DEFAULT_PW  (16'h1234)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .state           (state),
        .is_star_pressed (is_star_pressed),
        .correct         (correct),
        .pw_updated      (pw_updated),
        .entry_error     (entry_error),
        .lockout_active  (lockout_active),
        .digit_count     (digit_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: entry as a queue of digits, lockout as remaining active cycles.
    int         m_digits[$];
    logic [15:0] m_pw;
    logic [2:0] m_prev;
    int         m_lock;
    logic       m_star, m_corr, m_upd, m_err;

    function automatic logic [15:0] entry_value();
        logic [15:0] v = 16'h0;
        foreach (m_digits[i]) v = v * 16 + 16'(m_digits[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_digits.delete();
        m_pw   = 16'h1234;
        m_prev = 3'd0;
        m_lock = 0;
        m_star = 0; m_corr = 0; m_upd = 0; m_err = 0;
    endfunction

    function automatic void model_step(input logic kv, input logic [3:0] kc, input logic [2:0] s);
        bit locked_now = (m_lock > 0);
        bit ignored    = (s == 3'd0) || (s == 3'd4) || (s == 3'd6) || locked_now;
        m_star = 0; m_corr = 0; m_upd = 0; m_err = 0;
        if (m_lock > 0) m_lock--;
        if (s == 3'd7 && m_prev != 3'd7) m_lock = LOCK;
        if (s != m_prev) begin
            m_digits.delete();
        end else if (kv && !ignored) begin
            if (kc < 10) begin
                if (m_digits.size() < DIGITS) m_digits.push_back(int'(kc));
                else m_err = 1;
            end else if (kc == 4'hB) begin
                m_digits.delete();
            end else if (kc == 4'hA) begin
                if (s == 3'd5) begin
                    if (m_digits.size() == DIGITS) begin
                        m_pw  = entry_value();
                        m_upd = 1;
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    m_star = 1;
                    m_corr = (m_digits.size() == DIGITS) && (entry_value() == m_pw);
                    if (s == 3'd7 && !m_corr) m_lock = LOCK;
                end
                m_digits.delete();
            end else begin
                m_err = 1;
            end
        end
        m_prev = s;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {is_star_pressed, correct, pw_updated, entry_error, lockout_active, digit_count};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_star, m_corr, m_upd, m_err, m_lock > 0, 3'(m_digits.size())};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b (star,corr,upd,err,lock,cnt)",
                     name, $time, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic cycle(input logic rst, input logic kv, input logic [3:0] kc,
                         input logic [2:0] s);
        @(negedge clk);
        reset = rst; key_valid = kv; key_code = kc; state = s;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(kv, kc, s);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic [2:0] st;
        logic [7:0] exp;   // {star, correct, pw_updated, entry_error, lockout, count[2:0]}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic kv, input logic [3:0] kc, input logic [2:0] st,
                                input logic [7:0] exp);
        vec_t v;
        v.kv = kv; v.kc = kc; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        int st_pick[10] = '{0, 1, 1, 2, 3, 4, 5, 6, 7, 7};
        logic [2:0] cur;

        // Directed table, hand-derived expectations.
        add(0, 4'h0, 1, 8'b00000_000);
        add(1, 4'h1, 1, 8'b00000_001);
        add(1, 4'h2, 1, 8'b00000_010);
        add(1, 4'h3, 1, 8'b00000_011);
        add(1, 4'h4, 1, 8'b00000_100);
        add(1, 4'hA, 1, 8'b11000_000);   // 1234* matches default
        add(0, 4'h0, 1, 8'b00000_000);
        add(1, 4'h1, 1, 8'b00000_001);
        add(1, 4'h2, 1, 8'b00000_010);
        add(1, 4'h3, 1, 8'b00000_011);
        add(1, 4'hA, 1, 8'b10000_000);   // short entry
        add(1, 4'h1, 1, 8'b00000_001);
        add(1, 4'h2, 1, 8'b00000_010);
        add(1, 4'h3, 1, 8'b00000_011);
        add(1, 4'h4, 1, 8'b00000_100);
        add(1, 4'h5, 1, 8'b00010_100);   // fifth digit rejected
        add(1, 4'hB, 1, 8'b00000_000);
        add(1, 4'h1, 1, 8'b00000_001);
        add(1, 4'h2, 1, 8'b00000_010);
        add(1, 4'hB, 1, 8'b00000_000);
        add(1, 4'h3, 1, 8'b00000_001);
        add(1, 4'h4, 1, 8'b00000_010);
        add(1, 4'hA, 1, 8'b10000_000);   // 12#34* -> two digits only
        add(1, 4'hE, 1, 8'b00010_000);   // illegal code
        add(1, 4'h7, 1, 8'b00000_001);
        add(1, 4'h5, 2, 8'b00000_000);   // key with state change dropped
        add(0, 4'h0, 2, 8'b00000_000);
        add(0, 4'h0, 5, 8'b00000_000);
        add(1, 4'h9, 5, 8'b00000_001);
        add(1, 4'h8, 5, 8'b00000_010);
        add(1, 4'h7, 5, 8'b00000_011);
        add(1, 4'h6, 5, 8'b00000_100);
        add(1, 4'hA, 5, 8'b00100_000);   // program 9876
        add(0, 4'h0, 1, 8'b00000_000);
        add(1, 4'h9, 1, 8'b00000_001);
        add(1, 4'h8, 1, 8'b00000_010);
        add(1, 4'h7, 1, 8'b00000_011);
        add(1, 4'h6, 1, 8'b00000_100);
        add(1, 4'hA, 1, 8'b11000_000);
        add(1, 4'h1, 1, 8'b00000_001);
        add(1, 4'h2, 1, 8'b00000_010);
        add(1, 4'h3, 1, 8'b00000_011);
        add(1, 4'h4, 1, 8'b00000_100);
        add(1, 4'hA, 1, 8'b10000_000);   // old password no longer valid
        add(0, 4'h0, 5, 8'b00000_000);
        add(1, 4'h1, 5, 8'b00000_001);
        add(1, 4'hA, 5, 8'b00010_000);   // short program attempt
        add(0, 4'h0, 3, 8'b00000_000);
        add(1, 4'h1, 7, 8'b00001_000);   // enter lock
        for (int i = 0; i < 7; i++) add(1, 4'h9, 7, 8'b00001_000);
        add(0, 4'h0, 7, 8'b00000_000);   // lockout expired after 8 cycles
        add(1, 4'h9, 7, 8'b00000_001);
        add(1, 4'h8, 7, 8'b00000_010);
        add(1, 4'h7, 7, 8'b00000_011);
        add(1, 4'h6, 7, 8'b00000_100);
        add(1, 4'hA, 7, 8'b11000_000);
        add(1, 4'h1, 7, 8'b00000_001);
        add(1, 4'h2, 7, 8'b00000_010);
        add(1, 4'hA, 7, 8'b10001_000);   // mismatch restarts lockout
        for (int i = 0; i < 7; i++) add(1, 4'h4, 7, 8'b00001_000);
        add(1, 4'h5, 7, 8'b00000_000);

        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; state = 3'd0;
        model_reset();
        #1;
        check("reset_async", dut_vec(), 8'h00);
        @(posedge clk); #1;
        check("reset_hold", dut_vec(), 8'h00);

        foreach (vecs[i]) begin
            cycle(0, vecs[i].kv, vecs[i].kc, vecs[i].st);
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Async reset between edges mid-program entry, then default password is back.
        cycle(0, 0, 4'h0, 5);
        cycle(0, 1, 4'h5, 5);
        cycle(0, 1, 4'h5, 5);
        check("pre_rst_count", {5'b0, digit_count}, 8'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst", dut_vec(), 8'h00);
        cycle(0, 0, 4'h0, 1);
        cycle(0, 1, 4'h1, 1);
        cycle(0, 1, 4'h2, 1);
        cycle(0, 1, 4'h3, 1);
        cycle(0, 1, 4'h4, 1);
        cycle(0, 1, 4'hA, 1);
        check("rst_default_pw", {6'b0, is_star_pressed, correct}, 8'b11);

        // Random stimulus against the model.
        cur = 3'd1;
        for (int i = 0; i < 3000; i++) begin
            logic       rst, kv;
            logic [3:0] kc;
            int         r;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) cur = 3'(st_pick[$urandom_range(0, 9)]);
            kv = ($urandom_range(0, 9) < 6);
            r  = $urandom_range(0, 9);
            if (r < 6)       kc = 4'($urandom_range(1, 4));
            else if (r < 8)  kc = 4'hA;
            else if (r == 8) kc = 4'hB;
            else             kc = 4'($urandom_range(12, 15));
            cycle(rst, kv, kc, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
